// File: rtl/mc_datapath.sv
// Multicycle RV32/RV64 datapath: register file, shared ALU, immediate generation, PC logic and control FSM.
// Optional retired-instruction counter is built only when MC_DP_INSTRET_EN is defined.
module mc_datapath #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     NREGS    = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            imem_valid,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic [XLEN-1:0] dmem_rdata,
    input  logic            dmem_valid,
    output logic [XLEN-1:0] pc,
    output logic            halt,
    output logic [31:0]     instret
);
    localparam int unsigned SHW    = $clog2(XLEN);
    localparam int unsigned RIW    = $clog2(NREGS);
    localparam int unsigned AW     = $clog2(XLEN / 8);
    localparam logic [2:0]  MEM_F3 = (XLEN == 64) ? 3'b011 : 3'b010;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

    state_t          state;
    logic [31:0]     ir;
    logic [XLEN-1:0] a, b, imm, alu_out;
    logic [XLEN-1:0] regs [NREGS];
    logic            dmem_req_q, dmem_we_q;
    logic [XLEN-1:0] dmem_addr_q, dmem_wdata_q;

    logic [6:0]      opcode;
    logic [2:0]      f3;
    logic [4:0]      rd, rs1, rs2;
    logic            is_r, is_load, is_store, is_branch, is_jal;
    logic            legal, use_rs1, use_rs2, use_rd, bad_idx, sh_ok;
    logic [31:0]     imm32;
    logic [XLEN-1:0] op2, alu_res, addr_sum, target, pc_plus4;
    logic [SHW-1:0]  shamt;
    logic            alt, br_taken;

    function automatic logic idx_bad(input logic [4:0] i);
        return (NREGS < 32) && (32'(i) >= NREGS);
    endfunction

    assign opcode    = ir[6:0];
    assign f3        = ir[14:12];
    assign rd        = ir[11:7];
    assign rs1       = ir[19:15];
    assign rs2       = ir[24:20];
    assign is_r      = (opcode == OP_R);
    assign is_load   = (opcode == OP_LOAD);
    assign is_store  = (opcode == OP_STORE);
    assign is_branch = (opcode == OP_BRANCH);
    assign is_jal    = (opcode == OP_JAL);
    // Shift-immediate upper bits: shamt is 5 bits on RV32, so ir[25] must be clear there
    assign sh_ok     = (XLEN == 64) || !ir[25];

    always_comb begin
        legal   = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        use_rd  = 1'b0;
        imm32   = '0;
        case (opcode)
            OP_R: begin
                legal   = (ir[31:25] == 7'b0000000) ||
                          (ir[31:25] == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101));
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                use_rd  = 1'b1;
            end
            OP_I: begin
                case (f3)
                    3'b001:  legal = sh_ok && (ir[31:26] == 6'b000000);
                    3'b101:  legal = sh_ok && (ir[31:26] == 6'b000000 || ir[31:26] == 6'b010000);
                    3'b011:  legal = 1'b0;
                    default: legal = 1'b1;
                endcase
                use_rs1 = 1'b1;
                use_rd  = 1'b1;
                imm32   = {{20{ir[31]}}, ir[31:20]};
            end
            OP_LOAD: begin
                legal   = (f3 == MEM_F3);
                use_rs1 = 1'b1;
                use_rd  = 1'b1;
                imm32   = {{20{ir[31]}}, ir[31:20]};
            end
            OP_STORE: begin
                legal   = (f3 == MEM_F3);
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                imm32   = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            end
            OP_BRANCH: begin
                legal   = (f3 == 3'b000) || (f3 == 3'b001);
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                imm32   = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            end
            OP_JAL: begin
                legal   = 1'b1;
                use_rd  = 1'b1;
                imm32   = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            end
            default: legal = 1'b0;
        endcase
    end

    assign bad_idx = (use_rs1 && idx_bad(rs1)) || (use_rs2 && idx_bad(rs2)) ||
                     (use_rd && idx_bad(rd));

    assign op2      = is_r ? b : imm;
    assign shamt    = op2[SHW-1:0];
    assign alt      = ir[30] && (is_r || f3 == 3'b101);
    assign addr_sum = a + imm;
    assign target   = pc + imm;
    assign pc_plus4 = pc + XLEN'(4);
    assign br_taken = (a == b) ^ f3[0];

    always_comb begin
        alu_res = '0;
        case (f3)
            3'b000:  alu_res = (alt && is_r) ? a - op2 : a + op2;
            3'b001:  alu_res = a << shamt;
            3'b010:  alu_res = XLEN'($signed(a) < $signed(op2));
            3'b011:  alu_res = XLEN'(a < op2);
            3'b100:  alu_res = a ^ op2;
            3'b101:  alu_res = alt ? XLEN'($signed(a) >>> shamt) : a >> shamt;
            3'b110:  alu_res = a | op2;
            default: alu_res = a & op2;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= FETCH;
            pc           <= RESET_PC;
            ir           <= '0;
            a            <= '0;
            b            <= '0;
            imm          <= '0;
            alu_out      <= '0;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= '0;
            for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            case (state)
                FETCH: if (imem_valid) begin
                    ir    <= imem_rdata;
                    state <= DECODE;
                end
                DECODE: begin
                    a     <= (rs1 == 5'd0) ? '0 : regs[rs1[RIW-1:0]];
                    b     <= (rs2 == 5'd0) ? '0 : regs[rs2[RIW-1:0]];
                    imm   <= XLEN'($signed(imm32));
                    state <= (!legal || bad_idx) ? HALT : EXEC;
                end
                EXEC: begin
                    if (is_load || is_store) begin
                        if (addr_sum[AW-1:0] != '0) begin
                            state <= HALT;
                        end else begin
                            dmem_req_q   <= 1'b1;
                            dmem_we_q    <= is_store;
                            dmem_addr_q  <= addr_sum;
                            dmem_wdata_q <= b;
                            state        <= MEM;
                        end
                    end else if (is_branch) begin
                        if (br_taken && target[1]) begin
                            state <= HALT;
                        end else begin
                            pc    <= br_taken ? target : pc_plus4;
                            state <= FETCH;
                        end
                    end else if (is_jal) begin
                        if (target[1]) begin
                            state <= HALT;
                        end else begin
                            alu_out <= pc_plus4;
                            pc      <= target;
                            state   <= WB;
                        end
                    end else begin
                        alu_out <= alu_res;
                        state   <= WB;
                    end
                end
                MEM: if (dmem_valid) begin
                    dmem_req_q <= 1'b0;
                    dmem_we_q  <= 1'b0;
                    if (dmem_we_q) begin
                        pc    <= pc_plus4;
                        state <= FETCH;
                    end else begin
                        alu_out <= dmem_rdata;
                        state   <= WB;
                    end
                end
                WB: begin
                    if (rd != 5'd0) regs[rd[RIW-1:0]] <= alu_out;
                    if (!is_jal) pc <= pc_plus4;
                    state <= FETCH;
                end
                default: state <= HALT;
            endcase
        end
    end

    // Reset gates the request side combinationally so an in-flight access is dropped at once
    assign imem_req   = (state == FETCH) && !reset;
    assign imem_addr  = reset ? '0 : pc;
    assign dmem_req   = dmem_req_q && !reset;
    assign dmem_we    = dmem_we_q && !reset;
    assign dmem_addr  = reset ? '0 : dmem_addr_q;
    assign dmem_wdata = reset ? '0 : dmem_wdata_q;
    assign halt       = (state == HALT);

`ifdef MC_DP_INSTRET_EN
    logic [31:0] instret_q;
    logic        retire;

    assign retire = (state == WB) ||
                    (state == MEM && dmem_valid && dmem_we_q) ||
                    (state == EXEC && is_branch && !(br_taken && target[1]));

    always_ff @(posedge clk) begin
        if (reset) instret_q <= '0;
        else if (retire) instret_q <= instret_q + 32'd1;
    end

    assign instret = instret_q;
`else
    assign instret = '0;
`endif

endmodule
